imem_responder: RTL and testbench

//  Instruction-memory responder: the memory end of the fetch interface. It accepts

---
 rtl/imem_responder.sv | 120 ++++++++++++
 tb/tb_imem_responder.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
`default_nettype none
// ============================================================================
// Module   : imem_responder
// Brief    : Instruction-memory end of the fetch interface. Returns one word
//            per accepted PC fetch after a fixed number of wait states.
// Revision : 1.0  initial release
// ============================================================================
module imem_responder #(
    parameter int    DEPTH_WORDS = 1024,
    parameter int    WAIT_CYCLES = 2,
    parameter string INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_instr,
    output logic [31:0] rsp_addr,
    output logic        rsp_err,
    input  logic        prog_we,
    input  logic [31:0] prog_addr,
    input  logic [31:0] prog_wdata
);

    localparam int          c_aw        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] c_depth     = 32'(DEPTH_WORDS);
    localparam logic [31:0] c_nop       = 32'h0000_0013;
    localparam logic [3:0]  c_wait_load = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_addr;
    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0] w_fetch_addr;
    logic        w_fetch_fault;
    logic [31:0] w_fetch_word;

    function automatic logic addr_fault(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ({2'b00, a[31:2]} >= c_depth);
    endfunction

    function automatic logic [c_aw-1:0] word_idx(input logic [31:0] a);
        return a[c_aw+1:2];
    endfunction

    // With zero wait states the capture happens on the accept edge itself,
    // so the live request address stands in for the latched one.
    assign w_fetch_addr  = (r_state == S_IDLE) ? req_addr : r_addr;
    assign w_fetch_fault = addr_fault(w_fetch_addr);
    assign w_fetch_word  = mem[word_idx(w_fetch_addr)];

    assign req_ready = (r_state == S_IDLE);

    always_ff @(posedge clk) begin
        if (prog_we && !addr_fault(prog_addr)) begin
            mem[word_idx(prog_addr)] <= prog_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_addr    <= 32'd0;
            rsp_valid <= 1'b0;
            rsp_instr <= 32'd0;
            rsp_addr  <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_addr <= req_addr;
                        if (WAIT_CYCLES == 0) begin
                            rsp_instr <= w_fetch_fault ? c_nop : w_fetch_word;
                            rsp_err   <= w_fetch_fault;
                            rsp_addr  <= w_fetch_addr;
                            rsp_valid <= 1'b1;
                            r_state   <= S_RESP;
                        end else begin
                            r_cnt   <= c_wait_load;
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        // Array read sees the pre-edge contents: read-before-write.
                        rsp_instr <= w_fetch_fault ? c_nop : w_fetch_word;
                        rsp_err   <= w_fetch_fault;
                        rsp_addr  <= w_fetch_addr;
                        rsp_valid <= 1'b1;
                        r_state   <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_responder.sv
`default_nettype none
// Bench for imem_responder: two instances (2 and 0 wait states) checked every
// cycle against a timing-arithmetic model, plus directed literal checks.
module tb_imem_responder;

    localparam int DEPTH = 64;
    localparam int WAITS [2] = '{2, 0};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid [2];
    logic        req_ready [2];
    logic [31:0] req_addr  [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_instr [2];
    logic [31:0] rsp_addr  [2];
    logic        rsp_err   [2];
    logic        prog_we   [2];
    logic [31:0] prog_addr [2];
    logic [31:0] prog_wdata[2];

    int n_checks = 0;
    int n_err    = 0;
    bit checking = 1'b0;

    always #5 clk = ~clk;

    imem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2), .INIT_FILE("")) u_dut0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_instr(rsp_instr[0]),
        .rsp_addr(rsp_addr[0]), .rsp_err(rsp_err[0]),
        .prog_we(prog_we[0]), .prog_addr(prog_addr[0]), .prog_wdata(prog_wdata[0])
    );

    imem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0), .INIT_FILE("")) u_dut1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_instr(rsp_instr[1]),
        .rsp_addr(rsp_addr[1]), .rsp_err(rsp_err[1]),
        .prog_we(prog_we[1]), .prog_addr(prog_addr[1]), .prog_wdata(prog_wdata[1])
    );

    // Model: a fetch accepted in cycle A is captured on the edge ending cycle
    // A+W and is presented from cycle A+1+W until the handshake.
    int          cyc = 0;
    bit          m_busy  [2] = '{1'b0, 1'b0};
    int          m_acc   [2];
    logic [31:0] m_addr  [2];
    logic [31:0] m_instr [2];
    logic [31:0] m_raddr [2];
    logic        m_err   [2];
    logic [31:0] m_mem   [2][DEPTH];

    always @(posedge reset) begin
        for (int d = 0; d < 2; d++) m_busy[d] = 1'b0;
    end

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                m_busy[d] = 1'b0;
            end else begin
                if (m_busy[d]) begin
                    if (cyc >= m_acc[d] + 1 + WAITS[d] && rsp_ready[d]) m_busy[d] = 1'b0;
                end else if (req_valid[d]) begin
                    m_busy[d] = 1'b1;
                    m_acc[d]  = cyc;
                    m_addr[d] = req_addr[d];
                end
                if (m_busy[d] && cyc == m_acc[d] + WAITS[d]) begin
                    m_raddr[d] = m_addr[d];
                    m_err[d]   = (m_addr[d] % 4 != 0) || ((m_addr[d] >> 2) >= DEPTH);
                    m_instr[d] = m_err[d] ? 32'h0000_0013 : m_mem[d][int'(m_addr[d] >> 2)];
                end
            end
            if (prog_we[d] && prog_addr[d] % 4 == 0 && (prog_addr[d] >> 2) < DEPTH)
                m_mem[d][int'(prog_addr[d] >> 2)] = prog_wdata[d];
        end
        cyc++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            for (int d = 0; d < 2; d++) begin
                automatic bit exp_v = m_busy[d] && (cyc >= m_acc[d] + 1 + WAITS[d]);
                chk($sformatf("model req_ready dut%0d", d), {31'd0, req_ready[d]}, {31'd0, !m_busy[d]});
                chk($sformatf("model rsp_valid dut%0d", d), {31'd0, rsp_valid[d]}, {31'd0, exp_v});
                if (exp_v) begin
                    chk($sformatf("model rsp_instr dut%0d", d), rsp_instr[d], m_instr[d]);
                    chk($sformatf("model rsp_addr dut%0d", d), rsp_addr[d], m_raddr[d]);
                    chk($sformatf("model rsp_err dut%0d", d), {31'd0, rsp_err[d]}, {31'd0, m_err[d]});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic prog(input int d, input logic [31:0] a, input logic [31:0] data);
        prog_we[d] = 1'b1; prog_addr[d] = a; prog_wdata[d] = data;
        tick();
        prog_we[d] = 1'b0;
    endtask

    task automatic do_fetch(input int d, input logic [31:0] a, input logic [31:0] exp_i,
                            input logic exp_e, input string nm);
        int n;
        req_valid[d] = 1'b1; req_addr[d] = a; rsp_ready[d] = 1'b1;
        chk({nm, " ready"}, {31'd0, req_ready[d]}, 32'd1);
        tick();
        req_valid[d] = 1'b0;
        req_addr[d]  = 32'hFFFF_FFF0;
        n = 0;
        while (!rsp_valid[d] && n < 40) begin tick(); n++; end
        if (!rsp_valid[d]) begin
            n_checks++; n_err++;
            $display("FAIL %s timeout: rsp_valid got 0 expected 1", nm);
        end else begin
            chk({nm, " instr"}, rsp_instr[d], exp_i);
            chk({nm, " err"}, {31'd0, rsp_err[d]}, {31'd0, exp_e});
            chk({nm, " addr"}, rsp_addr[d], a);
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_addr[d] = 32'd0; rsp_ready[d] = 1'b1;
            prog_we[d] = 1'b0; prog_addr[d] = 32'd0; prog_wdata[d] = 32'd0;
        end
        tick(); tick();
        checking = 1'b1;
        for (int d = 0; d < 2; d++) begin
            chk("reset rsp_valid", {31'd0, rsp_valid[d]}, 32'd0);
            chk("reset rsp_instr", rsp_instr[d], 32'd0);
            chk("reset rsp_addr", rsp_addr[d], 32'd0);
            chk("reset rsp_err", {31'd0, rsp_err[d]}, 32'd0);
        end
        reset = 1'b0;
        chk("post-reset req_ready", {31'd0, req_ready[0]}, 32'd1);

        prog(0, 32'h0, 32'h0050_0093);
        prog(0, 32'h4, 32'h00A0_0113);

        // Directed: accept at cycle 0, valid at cycle 3, idle at cycle 4.
        req_valid[0] = 1'b1; req_addr[0] = 32'h0; rsp_ready[0] = 1'b1;
        tick();
        req_valid[0] = 1'b0;
        chk("t1 c1 valid", {31'd0, rsp_valid[0]}, 32'd0);
        chk("t1 c1 ready", {31'd0, req_ready[0]}, 32'd0);
        tick();
        chk("t1 c2 valid", {31'd0, rsp_valid[0]}, 32'd0);
        tick();
        chk("t1 c3 valid", {31'd0, rsp_valid[0]}, 32'd1);
        chk("t1 c3 instr", rsp_instr[0], 32'h0050_0093);
        chk("t1 c3 err", {31'd0, rsp_err[0]}, 32'd0);
        chk("t1 c3 addr", rsp_addr[0], 32'h0);
        tick();
        chk("t1 c4 ready", {31'd0, req_ready[0]}, 32'd1);
        chk("t1 c4 valid", {31'd0, rsp_valid[0]}, 32'd0);

        // Backpressure
        req_valid[0] = 1'b1; req_addr[0] = 32'h4; rsp_ready[0] = 1'b0;
        tick();
        req_valid[0] = 1'b0;
        tick(); tick();
        for (int i = 0; i < 5; i++) begin
            chk("t2 hold valid", {31'd0, rsp_valid[0]}, 32'd1);
            chk("t2 hold instr", rsp_instr[0], 32'h00A0_0113);
            chk("t2 hold addr", rsp_addr[0], 32'h4);
            chk("t2 hold ready", {31'd0, req_ready[0]}, 32'd0);
            tick();
        end
        rsp_ready[0] = 1'b1;
        chk("t2 release valid", {31'd0, rsp_valid[0]}, 32'd1);
        tick();
        chk("t2 after valid", {31'd0, rsp_valid[0]}, 32'd0);
        chk("t2 after ready", {31'd0, req_ready[0]}, 32'd1);

        // Faults
        do_fetch(0, 32'h6, 32'h0000_0013, 1'b1, "t3 misaligned");
        do_fetch(0, 32'(4 * DEPTH), 32'h0000_0013, 1'b1, "t3 range");
        do_fetch(0, 32'(4 * DEPTH - 4), 32'hxxxx_xxxx, 1'b0, "t3 last word unwritten");

        // Program write, ignored misaligned write, collision
        prog(0, 32'h10, 32'hDEAD_BEEF);
        prog(0, 32'h12, 32'h0000_0BAD);
        prog(0, 32'(4 * DEPTH), 32'h0000_0BAD);
        do_fetch(0, 32'h10, 32'hDEAD_BEEF, 1'b0, "t4 prog");
        req_valid[0] = 1'b1; req_addr[0] = 32'h10;
        tick();
        req_valid[0] = 1'b0;
        tick();
        prog_we[0] = 1'b1; prog_addr[0] = 32'h10; prog_wdata[0] = 32'h1234_5678;
        tick();
        prog_we[0] = 1'b0;
        chk("t4 collision valid", {31'd0, rsp_valid[0]}, 32'd1);
        chk("t4 collision instr", rsp_instr[0], 32'hDEAD_BEEF);
        tick();
        req_valid[0] = 1'b1; req_addr[0] = 32'h10;
        tick();
        req_valid[0] = 1'b0;
        prog_we[0] = 1'b1; prog_addr[0] = 32'h10; prog_wdata[0] = 32'hCAFE_F00D;
        tick();
        prog_we[0] = 1'b0;
        tick();
        chk("t4 wait-write instr", rsp_instr[0], 32'hCAFE_F00D);
        tick();

        // Zero wait states, back-to-back
        prog(1, 32'h20, 32'h1111_1111);
        prog(1, 32'h24, 32'h2222_2222);
        prog(1, 32'h28, 32'h3333_3333);
        req_valid[1] = 1'b1; req_addr[1] = 32'h20; rsp_ready[1] = 1'b1;
        chk("t5 c0 ready", {31'd0, req_ready[1]}, 32'd1);
        tick();
        chk("t5 c1 valid", {31'd0, rsp_valid[1]}, 32'd1);
        chk("t5 c1 instr", rsp_instr[1], 32'h1111_1111);
        req_addr[1] = 32'h24;
        tick();
        chk("t5 c2 valid", {31'd0, rsp_valid[1]}, 32'd0);
        chk("t5 c2 ready", {31'd0, req_ready[1]}, 32'd1);
        tick();
        chk("t5 c3 instr", rsp_instr[1], 32'h2222_2222);
        req_addr[1] = 32'h28;
        tick();
        tick();
        chk("t5 c5 valid", {31'd0, rsp_valid[1]}, 32'd1);
        chk("t5 c5 instr", rsp_instr[1], 32'h3333_3333);
        req_valid[1] = 1'b0;
        tick();

        // Reset during WAIT
        req_valid[0] = 1'b1; req_addr[0] = 32'h0;
        tick();
        req_valid[0] = 1'b0;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        chk("t6 ready after release", {31'd0, req_ready[0]}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            chk("t6 no response", {31'd0, rsp_valid[0]}, 32'd0);
            tick();
        end
        do_fetch(0, 32'h0, 32'h0050_0093, 1'b0, "t6 refetch");
        do_fetch(1, 32'h24, 32'h2222_2222, 1'b0, "t6 dut1 refetch");

        tick();
        checking = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
